wb_host_bridge: RTL and testbench
=================================

WB_HOST_BRIDGE -- requirements
Module: wb_host_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum clk_i cycles stb_o waits for ack_i (1..65535).
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port rx_data  input  8  command byte from host link.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-006 SHALL have port tx_data  output  8  response byte to host link.
REQ-007 SHALL have port tx_valid  output  1  response valid; held until accepted.
REQ-008 SHALL have port tx_ready  input  1  link accepts tx_data when high with tx_valid.
REQ-009 SHALL have port adr_o  output  4  Wishbone address.
REQ-010 SHALL have port dat_o  output  8  Wishbone write data.
REQ-011 SHALL have port dat_i  input  8  Wishbone read data.
REQ-012 SHALL have port we_o  output  1  Wishbone write enable.
REQ-013 SHALL have port stb_o  output  1  Wishbone strobe.
REQ-014 SHALL have port ack_i  input  1  Wishbone acknowledge.
REQ-015 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-016 SHALL have port err_timeout  output  1  sticky; set on bus timeout.
REQ-017 SHALL have port err_overrun  output  1  sticky; set on dropped rx byte.

Function
REQ-018 SHALL decode header byte: bit7 = write, bits3:0 = address, bits6:4 = reserved.
REQ-019 SHALL implement FSM states IDLE, GET_DATA, BUS, RESP.
REQ-020 IDLE: rx_valid with bits6:4 = 000 SHALL latch adr/we; write -> GET_DATA, read -> BUS.
REQ-021 IDLE: rx_valid with bits6:4 != 000 SHALL be discarded, stay IDLE, no response, no bus cycle.
REQ-022 GET_DATA: next rx_valid SHALL latch dat_o and go to BUS; no timeout while waiting.
REQ-023 BUS: stb_o SHALL assert the cycle after entry, with adr_o/we_o/dat_o stable until stb_o falls.
REQ-024 BUS: first cycle with stb_o=1 and ack_i=1 SHALL deassert stb_o next cycle (no second strobe cycle), capture dat_i if read, go to RESP.
REQ-025 BUS: wait counter SHALL count stb_o-high cycles; at TIMEOUT cycles without ack_i, stb_o drops, err_timeout sets, go to RESP.
REQ-026 ack_i while stb_o=0 SHALL be ignored.
REQ-027 RESP: tx_valid=1; tx_data = captured dat_i (read ack), 0x00 (write ack), 0xFF (timeout).
REQ-028 RESP: tx_valid and tx_data SHALL hold until tx_valid&tx_ready; then return to IDLE next cycle.
REQ-029 rx_valid in BUS or RESP SHALL drop the byte and set err_overrun.
REQ-030 Sticky flags SHALL clear only on reset.
REQ-031 Back-to-back: header accepted in the IDLE cycle directly after RESP handshake.

Reset
REQ-032 On rst_i=0 at clock edge: state IDLE; stb_o, we_o, tx_valid, busy, err_timeout, err_overrun = 0; adr_o, dat_o, tx_data = 0; counter = 0.
REQ-033 Reset mid-BUS SHALL drop stb_o the next edge with no response emitted.
REQ-034 Outputs SHALL be defined from the first edge with rst_i=0 (no X on stb_o/tx_valid).

Verification
REQ-035 Write: rx 0x82, 0x5A; responder acks after 1 cycle -> one stb_o pulse, adr_o=2, we_o=1, dat_o=0x5A; tx_data=0x00.
REQ-036 Read: rx 0x03; responder drives dat_i=0x12 with ack -> we_o=0, adr_o=3, single strobe; tx_data=0x12.
REQ-037 Timeout: TIMEOUT=4, rx 0x01, ack_i never -> stb_o high exactly 4 cycles; tx_data=0xFF; err_timeout=1.
REQ-038 Backpressure/overrun: tx_ready=0 for 10 cycles in RESP, rx 0x05 injected -> tx_data stable, err_overrun=1, no new bus cycle.
REQ-039 Reserved bits: rx 0x70 -> no stb_o, no tx_valid, busy stays 0; following rx 0x00 handled normally.
REQ-040 Reset mid-BUS: rst_i=0 while stb_o=1 -> stb_o=0 next edge, flags 0, state IDLE.

Source files
------------

// File: rtl/wb_host_bridge.sv
// Byte-serial host link to Wishbone single-transfer bridge.
// Header byte: bit7 = write, bits3:0 = address; writes take one extra data byte.
module wb_host_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [3:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  output logic       we_o,
  output logic       stb_o,
  input  logic       ack_i,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    GET_DATA,
    BUS,
    RESP
  } state_t;

  state_t           state_q;
  logic [3:0]       adr_q;
  logic [7:0]       dat_q;
  logic [7:0]       tx_data_q;
  logic             we_q;
  logic             stb_q;
  logic             tx_valid_q;
  logic             busy_q;
  logic             err_to_q;
  logic             err_ov_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      tx_data_q  <= '0;
      we_q       <= 1'b0;
      stb_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_ov_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // Any byte arriving while a transfer or response is in flight is lost.
      if (rx_valid && (state_q == BUS || state_q == RESP)) begin
        err_ov_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (rx_valid && rx_data[6:4] == 3'b000) begin
            adr_q   <= rx_data[3:0];
            we_q    <= rx_data[7];
            busy_q  <= 1'b1;
            state_q <= rx_data[7] ? GET_DATA : BUS;
          end
        end
        GET_DATA: begin
          if (rx_valid) begin
            dat_q   <= rx_data;
            state_q <= BUS;
          end
        end
        BUS: begin
          // First BUS cycle raises the strobe; cnt_q counts completed strobe cycles.
          if (!stb_q) begin
            stb_q <= 1'b1;
            cnt_q <= '0;
          end else if (ack_i) begin
            stb_q      <= 1'b0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= we_q ? 8'h00 : dat_i;
            state_q    <= RESP;
          end else if (cnt_d == CNT_W'(TIMEOUT)) begin
            stb_q      <= 1'b0;
            err_to_q   <= 1'b1;
            tx_valid_q <= 1'b1;
            tx_data_q  <= 8'hFF;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign we_o        = we_q;
  assign stb_o       = stb_q;
  assign busy        = busy_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule

// File: tb/tb_wb_host_bridge.sv
// Directed plus randomized transactions against a per-command expectation model.
module tb_wb_host_bridge;

  localparam int unsigned TO = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       we_o;
  logic       stb_o;
  logic       ack_i;
  logic       busy;
  logic       err_timeout;
  logic       err_overrun;

  int n_vec = 0;
  int n_err = 0;
  bit exp_to = 1'b0;
  bit exp_ov = 1'b0;

  wb_host_bridge #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
    .we_o(we_o), .stb_o(stb_o), .ack_i(ack_i),
    .busy(busy), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_stb"}, 16'(stb_o), 16'd0);
    chk({tag, "_txv"}, 16'(tx_valid), 16'd0);
  endtask

  // One host command: header, optional data byte, bus transfer, response drain.
  // lat = strobe cycle (1-based) on which the responder acks, 0 = never.
  task automatic do_cmd(input logic [7:0] hdr, input logic [7:0] wd, input int lat,
                        input int gap, input int bp, input bit ovr, input logic [7:0] rdv);
    bit         wr;
    bit         timed_out;
    int         nstb;
    int         exp_n;
    int         nbp;
    logic [7:0] exp_tx;
    wr = hdr[7];
    rx_valid = 1'b1; rx_data = hdr;
    @(negedge clk_i);
    rx_valid = 1'b0; rx_data = 8'($urandom);
    if (hdr[6:4] != 3'b000) begin
      repeat (3) begin
        chk_idle("rsv");
        @(negedge clk_i);
      end
      return;
    end
    if (wr) begin
      repeat (gap) begin
        chk("getdata_stb", 16'(stb_o), 16'd0);
        chk("getdata_busy", 16'(busy), 16'd1);
        @(negedge clk_i);
      end
      rx_valid = 1'b1; rx_data = wd;
      @(negedge clk_i);
      rx_valid = 1'b0;
    end
    nstb = 0;
    for (int c = 0; c < 100 && !tx_valid; c++) begin
      if (stb_o) begin
        nstb++;
        chk("bus_adr", 16'(adr_o), 16'(hdr[3:0]));
        chk("bus_we", 16'(we_o), 16'(wr));
        if (wr) chk("bus_dat", 16'(dat_o), 16'(wd));
        ack_i = (nstb == lat);
        dat_i = (nstb == lat) ? rdv : 8'($urandom);
      end else begin
        ack_i = 1'($urandom_range(0, 1));
        dat_i = 8'($urandom);
      end
      @(negedge clk_i);
    end
    ack_i = 1'b0;
    timed_out = (lat == 0) || (lat > int'(TO));
    exp_n  = timed_out ? int'(TO) : lat;
    exp_tx = timed_out ? 8'hFF : (wr ? 8'h00 : rdv);
    if (timed_out) exp_to = 1'b1;
    chk("resp_seen", 16'(tx_valid), 16'd1);
    chk("stb_cycles", 16'(nstb), 16'(exp_n));
    chk("resp_stb_low", 16'(stb_o), 16'd0);
    chk("resp_data", 16'(tx_data), 16'(exp_tx));
    chk("err_timeout", 16'(err_timeout), 16'(exp_to));
    nbp = (ovr && bp == 0) ? 1 : bp;
    for (int i = 0; i < nbp; i++) begin
      rx_valid = ovr && (i == 0);
      rx_data  = 8'h05;
      if (rx_valid) exp_ov = 1'b1;
      @(negedge clk_i);
      rx_valid = 1'b0;
      chk("hold_txv", 16'(tx_valid), 16'd1);
      chk("hold_data", 16'(tx_data), 16'(exp_tx));
      chk("hold_stb", 16'(stb_o), 16'd0);
    end
    tx_ready = 1'b1;
    @(negedge clk_i);
    tx_ready = 1'b0;
    chk("done_txv", 16'(tx_valid), 16'd0);
    chk("done_busy", 16'(busy), 16'd0);
    chk("err_overrun", 16'(err_overrun), 16'(exp_ov));
  endtask

  initial begin
    rst_i = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    ack_i = 1'b0; dat_i = '0;
    repeat (2) @(negedge clk_i);
    // Reset values
    chk_idle("reset");
    chk("reset_we", 16'(we_o), 16'd0);
    chk("reset_adr", 16'(adr_o), 16'd0);
    chk("reset_dat", 16'(dat_o), 16'd0);
    chk("reset_tx", 16'(tx_data), 16'd0);
    chk("reset_eto", 16'(err_timeout), 16'd0);
    chk("reset_eov", 16'(err_overrun), 16'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Write, read, timeout
    do_cmd(8'h82, 8'h5A, 1, 1, 0, 1'b0, 8'h00);
    do_cmd(8'h03, 8'h00, 1, 0, 0, 1'b0, 8'h12);
    do_cmd(8'h01, 8'h00, 0, 0, 0, 1'b0, 8'h00);

    // Backpressure with an overrun byte, then no further bus activity
    do_cmd(8'h04, 8'h00, 2, 0, 10, 1'b1, 8'hC3);
    repeat (3) begin
      chk_idle("post_ovr");
      @(negedge clk_i);
    end

    // Reserved header discarded, next header handled normally
    do_cmd(8'h70, 8'h00, 1, 0, 0, 1'b0, 8'h00);
    do_cmd(8'h00, 8'h00, 3, 0, 1, 1'b0, 8'hA5);

    // Randomized back-to-back commands
    for (int k = 0; k < 60; k++) begin
      logic [7:0] hdr;
      hdr = 8'($urandom);
      if ($urandom_range(0, 3) != 0) hdr[6:4] = 3'b000;
      do_cmd(hdr, 8'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
             int'($urandom_range(0, 4)), ($urandom_range(0, 4) == 0), 8'($urandom));
    end

    // Reset while the strobe is high
    rx_valid = 1'b1; rx_data = 8'h01;
    @(negedge clk_i);
    rx_valid = 1'b0;
    for (int c = 0; c < 10 && !stb_o; c++) @(negedge clk_i);
    chk("rstbus_stb_before", 16'(stb_o), 16'd1);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_idle("rstbus");
    chk("rstbus_eto", 16'(err_timeout), 16'd0);
    chk("rstbus_eov", 16'(err_overrun), 16'd0);
    rst_i = 1'b1;
    exp_to = 1'b0; exp_ov = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      chk_idle("rstbus_after");
    end
    do_cmd(8'h8F, 8'h3C, 2, 2, 1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
